maze_move_encoder: RTL and testbench

Upstream input stage for the maze game. Turns the five raw pushbuttons (up, down, left, right, centre) into the 3-bit `move` code, the centre-press flag and the `timer` strobe that the maze position controller samples. Buttons are synchronised and debounced, and each press becomes exactly one move. Moves are held stable across a whole tick so the controller always samples a clean code on its strobe edge.

---
 rtl/maze_pkg.sv | 28 ++
 rtl/maze_move_encoder_if.sv | 14 +
 rtl/btn_debounce.sv | 97 +++++++++
 rtl/maze_move_encoder.sv | 138 +++++++++++++
 tb/tb_maze_move_encoder.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared move codes, debouncer states and direction priority encoder
package maze_pkg;

  localparam logic [2:0] MOVE_STAY  = 3'b000;
  localparam logic [2:0] MOVE_LEFT  = 3'b001;
  localparam logic [2:0] MOVE_RIGHT = 3'b010;
  localparam logic [2:0] MOVE_DOWN  = 3'b011;
  localparam logic [2:0] MOVE_UP    = 3'b100;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_t;

  // udlr = {up, down, left, right}; later ifs override earlier ones, so up wins
  function automatic logic [2:0] encode_dir(input logic [3:0] udlr);
    logic [2:0] code;
    code = MOVE_STAY;
    if (udlr[0]) code = MOVE_RIGHT;
    if (udlr[1]) code = MOVE_LEFT;
    if (udlr[2]) code = MOVE_DOWN;
    if (udlr[3]) code = MOVE_UP;
    return code;
  endfunction

endpackage

// File: rtl/maze_move_encoder_if.sv
// rtl/maze_move_encoder_if.sv - pushbutton inputs and move/centre/timer outputs of the encoder
interface maze_move_encoder_if;
  logic       btnU;
  logic       btnD;
  logic       btnL;
  logic       btnR;
  logic       btnC;
  logic [2:0] move;
  logic       C;
  logic       timer;

  modport master (output btnU, btnD, btnL, btnR, btnC, input move, C, timer);
  modport slave  (input btnU, btnD, btnL, btnR, btnC, output move, C, timer);
endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - 2-flop synchroniser plus debounce FSM emitting one press pulse per press
// MOVE_AUTOREPEAT_EN adds the held output used by the repeat logic.
module btn_debounce
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
`ifdef MOVE_AUTOREPEAT_EN
  ,
  output logic held
`endif
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync_1, sync_2;
  deb_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic          press_next;

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      state  <= IDLE;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync_1 <= btn;
      sync_2 <= sync_1;
      state  <= state_next;
      cnt    <= cnt_next;
      press  <= press_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    press_next = 1'b0;
    case (state)
      IDLE: begin
        if (sync_2) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync_2) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = HELD;
          cnt_next   = '0;
          press_next = 1'b1;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      HELD: begin
        // the cycle that leaves HELD is already the first low cycle
        if (!sync_2) begin
          state_next = RELEASE_WAIT;
          cnt_next   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (sync_2) begin
          state_next = HELD;
          cnt_next   = '0;
        end else if (cnt >= CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef MOVE_AUTOREPEAT_EN
  assign held = (state == HELD) || (state == RELEASE_WAIT);
`endif

endmodule

// File: rtl/maze_move_encoder.sv
// rtl/maze_move_encoder.sv - debounced buttons to one-move-per-tick code with tick strobe
// MOVE_AUTOREPEAT_EN re-queues a held direction every REPEAT_TICKS ticks.
module maze_move_encoder
  import maze_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int TICK_DIV        = 10_000_000,
  parameter int REPEAT_TICKS    = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  maze_move_encoder_if.slave  bus
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  if (TICK_DIV < 4 || REPEAT_TICKS < 2) begin : g_cfg_check
    $error("maze_move_encoder: TICK_DIV must be >= 4 and REPEAT_TICKS >= 2");
  end

  logic [4:0]    raw, press;
  logic [TW-1:0] tick_cnt;
  logic          consume;
  logic [2:0]    press_code, refill;
  logic [2:0]    pend_move, pend_move_next;
  logic          pend_c, pend_c_next;
  logic [2:0]    move_q;
  logic          c_q, timer_req, timer_q;

  // bit order {U, D, L, R, C} so press[4:1] feeds the priority encoder directly
  assign raw = {bus.btnU, bus.btnD, bus.btnL, bus.btnR, bus.btnC};

`ifdef MOVE_AUTOREPEAT_EN
  logic [4:0] held;
`endif

  for (genvar i = 0; i < 5; i++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (raw[i]),
      .press (press[i])
`ifdef MOVE_AUTOREPEAT_EN
      ,
      .held  (held[i])
`endif
    );
  end

  assign consume = (tick_cnt == TICK_LAST);

`ifdef MOVE_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_TICKS - 1);

  logic [2:0]    rep_code;
  logic [RW-1:0] rep_cnt;
  logic          rep_armed, rep_held, repeat_fire, captured;

  always_comb begin
    rep_held = 1'b0;
    case (rep_code)
      MOVE_UP:    rep_held = held[4];
      MOVE_DOWN:  rep_held = held[3];
      MOVE_LEFT:  rep_held = held[2];
      MOVE_RIGHT: rep_held = held[1];
      default:    rep_held = 1'b0;
    endcase
  end

  assign captured    = (press_code != MOVE_STAY) && (consume || pend_move == MOVE_STAY);
  assign repeat_fire = rep_armed && rep_held && consume && (pend_move == MOVE_STAY)
                       && (rep_cnt == REP_LAST);

  // rep_cnt counts the consuming tick itself as 1, so the refill lands on tick REPEAT_TICKS
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rep_code  <= MOVE_STAY;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (captured) begin
      rep_code  <= press_code;
      rep_cnt   <= '0;
      rep_armed <= 1'b0;
    end else if (rep_armed && !rep_held) begin
      rep_armed <= 1'b0;
    end else if (consume) begin
      if (pend_move != MOVE_STAY) begin
        rep_armed <= 1'b1;
        rep_cnt   <= RW'(1);
      end else if (rep_armed) begin
        rep_cnt <= (rep_cnt == REP_LAST) ? '0 : rep_cnt + 1'b1;
      end
    end
  end
`endif

  always_comb begin
    refill = MOVE_STAY;
`ifdef MOVE_AUTOREPEAT_EN
    if (repeat_fire) refill = rep_code;
`endif
    press_code = encode_dir(press[4:1]);
    // a press arriving on the consume edge refills the freshly emptied slot
    if (consume)                     pend_move_next = (press_code != MOVE_STAY) ? press_code : refill;
    else if (pend_move == MOVE_STAY) pend_move_next = press_code;
    else                             pend_move_next = pend_move;
    pend_c_next = consume ? press[0] : (pend_c | press[0]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt  <= '0;
      pend_move <= MOVE_STAY;
      pend_c    <= 1'b0;
      move_q    <= MOVE_STAY;
      c_q       <= 1'b0;
      timer_req <= 1'b0;
      timer_q   <= 1'b0;
    end else begin
      tick_cnt  <= consume ? '0 : tick_cnt + 1'b1;
      pend_move <= pend_move_next;
      pend_c    <= pend_c_next;
      timer_req <= consume;
      timer_q   <= timer_req;
      if (consume) begin
        move_q <= pend_move;
        c_q    <= pend_c;
      end
    end
  end

  assign bus.move  = move_q;
  assign bus.C     = c_q;
  assign bus.timer = timer_q;

endmodule

// File: tb/tb_maze_move_encoder.sv
// tb/tb_maze_move_encoder.sv - directed tick-by-tick checks of the maze move encoder
module tb_maze_move_encoder;
  import maze_pkg::*;

  localparam int DEB  = 4;
  localparam int TDIV = 8;
  localparam int RPT  = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  maze_move_encoder_if bus ();

  maze_move_encoder #(
    .DEBOUNCE_CYCLES (DEB),
    .TICK_DIV        (TDIV),
    .REPEAT_TICKS    (RPT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // returns move/C seen while timer is high and move one cycle earlier
  task automatic wait_timer(input string name, output logic [2:0] m, output logic c,
                            output logic [2:0] m_prev);
    logic       found;
    logic [2:0] last;
    found  = 1'b0;
    m      = 3'bxxx;
    c      = 1'bx;
    last   = bus.move;
    m_prev = last;
    for (int i = 0; i < 4 * TDIV; i++) begin
      @(negedge clk);
      if (bus.timer === 1'b1) begin
        found  = 1'b1;
        m      = bus.move;
        c      = bus.C;
        m_prev = last;
        break;
      end
      last = bus.move;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout: timer=0 after %0d cycles, required timer=1", name, 4 * TDIV);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    bus.btnU = 1'b0;
    bus.btnD = 1'b0;
    bus.btnL = 1'b0;
    bus.btnR = 1'b0;
    bus.btnC = 1'b0;
    cycles(3);
    checks++;
    if (bus.move !== MOVE_STAY) begin errors++; $display("FAIL reset_move: got %b required 000", bus.move); end
    checks++;
    if (bus.C !== 1'b0) begin errors++; $display("FAIL reset_c: got %b required 0", bus.C); end
    checks++;
    if (bus.timer !== 1'b0) begin errors++; $display("FAIL reset_timer: got %b required 0", bus.timer); end
    rst_n = 1'b1;
    cycles(TDIV * 2);
  endtask

  task automatic test_clean_press();
    logic [2:0] m, mp;
    logic       c;
    logic [2:0] exp_m [0:2];
    exp_m = '{MOVE_STAY, MOVE_LEFT, MOVE_STAY};
    wait_timer("clean_align", m, c, mp);
    bus.btnL = 1'b1;
    fork
      begin cycles(20); bus.btnL = 1'b0; end
    join_none
    for (int t = 0; t < 3; t++) begin
      wait_timer("clean", m, c, mp);
      checks++;
      if (m !== exp_m[t]) begin errors++; $display("FAIL clean_move[%0d]: got %b required %b", t, m, exp_m[t]); end
      if (t == 1) begin
        checks++;
        if (mp !== MOVE_LEFT) begin errors++; $display("FAIL clean_setup: move before timer %b required 001", mp); end
        @(negedge clk);
        checks++;
        if (bus.timer !== 1'b0) begin errors++; $display("FAIL clean_timer_width: got %b required 0", bus.timer); end
        checks++;
        if (bus.move !== MOVE_LEFT) begin errors++; $display("FAIL clean_hold: got %b required 001", bus.move); end
      end
    end
    cycles(16);
  endtask

  task automatic test_bounce();
    logic [2:0] m, mp;
    logic       c;
    wait_timer("bounce_align", m, c, mp);
    for (int k = 0; k < 6; k++) begin
      bus.btnU = (k % 2 == 0);
      cycles(2);
    end
    bus.btnU = 1'b0;
    for (int t = 0; t < 3; t++) begin
      wait_timer("bounce", m, c, mp);
      checks++;
      if (m !== MOVE_STAY) begin errors++; $display("FAIL bounce_move[%0d]: got %b required 000", t, m); end
    end
    cycles(16);
  endtask

  task automatic test_same_cycle();
    logic [2:0] m, mp;
    logic       c;
    logic [2:0] exp_m [0:3];
    exp_m = '{MOVE_STAY, MOVE_DOWN, MOVE_STAY, MOVE_STAY};
    wait_timer("same_align", m, c, mp);
    bus.btnD = 1'b1;
    bus.btnR = 1'b1;
    fork
      begin cycles(10); bus.btnD = 1'b0; bus.btnR = 1'b0; end
    join_none
    for (int t = 0; t < 4; t++) begin
      wait_timer("same", m, c, mp);
      checks++;
      if (m !== exp_m[t]) begin errors++; $display("FAIL same_move[%0d]: got %b required %b", t, m, exp_m[t]); end
    end
    cycles(16);
  endtask

  task automatic test_centre_direction();
    logic [2:0] m, mp;
    logic       c;
    logic [2:0] exp_m [0:2];
    logic       exp_c [0:2];
    exp_m = '{MOVE_STAY, MOVE_LEFT, MOVE_STAY};
    exp_c = '{1'b0, 1'b1, 1'b0};
    wait_timer("centre_align", m, c, mp);
    bus.btnC = 1'b1;
    fork
      begin cycles(2); bus.btnL = 1'b1; cycles(10); bus.btnL = 1'b0; end
      begin cycles(10); bus.btnC = 1'b0; end
    join_none
    for (int t = 0; t < 3; t++) begin
      wait_timer("centre", m, c, mp);
      checks++;
      if (m !== exp_m[t]) begin errors++; $display("FAIL centre_move[%0d]: got %b required %b", t, m, exp_m[t]); end
      checks++;
      if (c !== exp_c[t]) begin errors++; $display("FAIL centre_c[%0d]: got %b required %b", t, c, exp_c[t]); end
    end
    cycles(16);
  endtask

  task automatic test_reset_mid();
    logic [2:0] m, mp;
    logic       c;
    logic [2:0] exp_m [0:2];
    exp_m = '{MOVE_STAY, MOVE_RIGHT, MOVE_STAY};
    wait_timer("rstmid_align", m, c, mp);
    bus.btnR = 1'b1;
    cycles(10);
    rst_n = 1'b0;
    cycles(1);
    checks++;
    if (bus.move !== MOVE_STAY) begin errors++; $display("FAIL rstmid_move: got %b required 000", bus.move); end
    checks++;
    if (bus.C !== 1'b0) begin errors++; $display("FAIL rstmid_c: got %b required 0", bus.C); end
    checks++;
    if (bus.timer !== 1'b0) begin errors++; $display("FAIL rstmid_timer: got %b required 0", bus.timer); end
    rst_n = 1'b1;
    for (int t = 0; t < 3; t++) begin
      wait_timer("rstmid", m, c, mp);
      checks++;
      if (m !== exp_m[t]) begin errors++; $display("FAIL rstmid_move[%0d]: got %b required %b", t, m, exp_m[t]); end
      if (t == 1) bus.btnR = 1'b0;
    end
    cycles(16);
  endtask

  task automatic test_held_button();
    logic [2:0] m, mp;
    logic       c;
    logic [2:0] exp_m [0:10];
`ifdef MOVE_AUTOREPEAT_EN
    exp_m = '{MOVE_STAY, MOVE_UP, MOVE_STAY, MOVE_STAY, MOVE_UP, MOVE_STAY,
              MOVE_STAY, MOVE_UP, MOVE_STAY, MOVE_STAY, MOVE_STAY};
`else
    exp_m = '{MOVE_STAY, MOVE_UP, MOVE_STAY, MOVE_STAY, MOVE_STAY, MOVE_STAY,
              MOVE_STAY, MOVE_STAY, MOVE_STAY, MOVE_STAY, MOVE_STAY};
`endif
    wait_timer("held_align", m, c, mp);
    bus.btnU = 1'b1;
    fork
      begin cycles(60); bus.btnU = 1'b0; end
    join_none
    for (int t = 0; t < 11; t++) begin
      wait_timer("held", m, c, mp);
      checks++;
      if (m !== exp_m[t]) begin errors++; $display("FAIL held_move[%0d]: got %b required %b", t, m, exp_m[t]); end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_same_cycle();
    test_centre_direction();
    test_reset_mid();
    test_held_button();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
